// File: rtl/des_input_sched.sv
// Block-level round-robin scheduler for the Triple-DES input assembler.
// Grants whole blocks to the I2C or SRAM byte source and hands finished blocks to the DES core.
module des_input_sched #(
  parameter int BLOCK_BYTES = 8,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2c_req,
  output logic             i2c_ack,
  input  logic             sram_req,
  output logic             sram_ack,
  output logic             dir_sel,
  output logic             read_enable,
  output logic             ib_clear,
  input  logic             ib_data_ready,
  output logic             blk_valid,
  output logic             blk_src,
  input  logic             des_ready,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             timeout_err
);

  // state    | meaning
  // IDLE     | no owner; arbitrate between pending requests
  // LOAD     | owner streams bytes into the assembler
  // WAIT_RDY | all strobes issued; waiting for the assembled block
  // HOLD     | block presented to the DES core until accepted
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_RDY = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] TO_VAL    = IDLE_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_n;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_n;
  logic [IDLE_W-1:0]   idle_inc;
  logic                owner_q, owner_n;
  logic                last_q, last_n;
  logic                abort_q, abort_n;
  logic                owner_req;
  logic                hit_to;
  logic                strobe;
  logic                present;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      byte_cnt_q <= byte_cnt_n;
      idle_cnt_q <= idle_cnt_n;
      owner_q    <= owner_n;
      last_q     <= last_n;
      abort_q    <= abort_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    byte_cnt_n = byte_cnt_q;
    idle_cnt_n = idle_cnt_q;
    owner_n    = owner_q;
    last_n     = last_q;
    abort_n    = 1'b0;
    strobe     = 1'b0;
    present    = 1'b0;
    owner_req  = owner_q ? sram_req : i2c_req;
    idle_inc   = idle_cnt_q + 1'b1;
    hit_to     = (TIMEOUT > 0) && (idle_inc == TO_VAL);

    case (state_q)
      IDLE: begin
        if (i2c_req || sram_req) begin
          // on a tie the source that was not served last wins
          owner_n    = (i2c_req && sram_req) ? ~last_q : sram_req;
          byte_cnt_n = '0;
          idle_cnt_n = '0;
          state_n    = LOAD;
        end
      end
      LOAD: begin
        if (owner_req) begin
          strobe     = 1'b1;
          byte_cnt_n = byte_cnt_q + 1'b1;
          idle_cnt_n = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            state_n = WAIT_RDY;
          end
        end else if (hit_to) begin
          abort_n = 1'b1;
        end else begin
          idle_cnt_n = idle_inc;
        end
      end
      WAIT_RDY: begin
        if (ib_data_ready) begin
          state_n = HOLD;
        end else if (hit_to) begin
          abort_n = 1'b1;
        end else begin
          idle_cnt_n = idle_inc;
        end
      end
      HOLD: begin
        present = 1'b1;
        if (des_ready) begin
          last_n     = owner_q;
          byte_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // a stalled owner loses its turn so the other source is preferred next
    if (abort_n) begin
      last_n     = owner_q;
      byte_cnt_n = '0;
      idle_cnt_n = '0;
      state_n    = IDLE;
    end
  end

  // outputs are forced quiet while reset is held, except the assembler clear
  assign read_enable = ~rst & strobe;
  assign i2c_ack     = ~rst & strobe & ~owner_q;
  assign sram_ack    = ~rst & strobe & owner_q;
  assign dir_sel     = ~rst & owner_q;
  assign blk_src     = ~rst & owner_q;
  assign blk_valid   = ~rst & present;
  assign busy        = ~rst & (state_q != IDLE);
  assign byte_cnt    = rst ? '0 : byte_cnt_q;
  assign timeout_err = ~rst & abort_q;
  assign ib_clear    = rst | abort_q;

endmodule
